dcache_direct_mapped: RTL

Direct-mapped, write-back, write-allocate data cache between the core's load/store unit and main memory. Serves word requests from the core. On a miss it evicts the victim line if dirty, then refills the line one 32-bit word per cycle over the main-memory port. That port carries mem_vis_signal, mem_vis_addr, writen_data and mem_data, and reads have fixed 1-cycle latency.

---
 rtl/dcache_direct_mapped.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate data cache, 4-word lines
module dcache_direct_mapped #(
  parameter int ADDR_WIDTH  = 17,
  parameter int LEN         = 32,
  parameter int BYTE_SIZE   = 8,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN-1:0]        req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  output logic [LEN-1:0]        resp_rdata,
  output logic [1:0]            mem_vis_signal,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [LEN-1:0]        writen_data,
  input  logic [LEN-1:0]        mem_data
);

  localparam int TAG_WIDTH = ADDR_WIDTH - 4 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND} state_t;

  state_t                  state_q;
  logic [2:0]              cnt_q;
  logic [ADDR_WIDTH-3:0]   waddr_q;
  logic                    write_q;
  logic [LEN-1:0]          wdata_q;
  logic [3:0]              be_q;
  logic [LINES-1:0]        valid_q;
  logic [LINES-1:0]        dirty_q;
  logic [TAG_WIDTH-1:0]    tag_q  [LINES];
  logic [LEN-1:0]          data_q [LINES][4];

  logic [INDEX_WIDTH-1:0]  idx;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [1:0]              off;
  logic [1:0]              next_word;
  logic [1:0]              fill_word;
  logic [LEN-1:0]          cur_word;
  logic [LEN-1:0]          merged;
  logic                    hit;
  logic                    respond;
  logic                    unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[1:0];
  assign off       = waddr_q[1:0];
  assign idx       = waddr_q[INDEX_WIDTH+1:2];
  assign req_tag   = waddr_q[ADDR_WIDTH-3:INDEX_WIDTH+2];
  assign next_word = cnt_q[1:0] + 2'd1;
  // Refill data arrives one cycle behind its READ, so cycle c fills word c-1.
  assign fill_word = cnt_q[1:0] - 2'd1;
  assign cur_word  = data_q[idx][off];
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
  assign respond   = ((state_q == S_LOOKUP) && hit) || (state_q == S_RESPOND);

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[i*BYTE_SIZE +: BYTE_SIZE] = wdata_q[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = respond;
  assign resp_rdata = respond ? (write_q ? merged : cur_word) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      waddr_q        <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      be_q           <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      mem_vis_signal <= MEM_NOP;
      mem_vis_addr   <= '0;
      writen_data    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            waddr_q <= req_addr[ADDR_WIDTH-1:2];
            write_q <= req_write;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          cnt_q <= '0;
          if (hit) begin
            if (write_q) dirty_q[idx] <= 1'b1;
            state_q <= S_IDLE;
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_q        <= S_WRITEBACK;
            mem_vis_signal <= MEM_WRITE;
            mem_vis_addr   <= {tag_q[idx], idx, 2'd0, 2'b00};
            writen_data    <= data_q[idx][0];
          end else begin
            state_q        <= S_REFILL;
            mem_vis_signal <= MEM_READ;
            mem_vis_addr   <= {req_tag, idx, 2'd0, 2'b00};
          end
        end
        S_WRITEBACK: begin
          if (cnt_q[1:0] == 2'd3) begin
            state_q        <= S_REFILL;
            cnt_q          <= '0;
            mem_vis_signal <= MEM_READ;
            mem_vis_addr   <= {req_tag, idx, 2'd0, 2'b00};
          end else begin
            cnt_q        <= cnt_q + 3'd1;
            mem_vis_addr <= {tag_q[idx], idx, next_word, 2'b00};
            writen_data  <= data_q[idx][next_word];
          end
        end
        S_REFILL: begin
          if (cnt_q == 3'd4) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            cnt_q        <= '0;
            state_q      <= S_RESPOND;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q < 3'd3) mem_vis_addr <= {req_tag, idx, next_word, 2'b00};
            else              mem_vis_signal <= MEM_NOP;
          end
        end
        S_RESPOND: begin
          if (write_q) dirty_q[idx] <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays keep their contents across reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state_q == S_REFILL) && (cnt_q != 3'd0)) data_q[idx][fill_word] <= mem_data;
      if ((state_q == S_REFILL) && (cnt_q == 3'd4)) tag_q[idx] <= req_tag;
      if (respond && write_q) data_q[idx][off] <= merged;
    end
  end

endmodule
